// File: rtl/text_term_pkg.sv
// Shared constants for the UART text terminal: screen geometry, control characters,
// the dump FSM encoding and the printable-character filter.
package text_term_pkg;

    localparam int TERM_COLS = 32;
    localparam int TERM_ROWS = 4;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_DEL   = 8'h7F;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ADDR = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_LOAD = 3'd3;
    localparam logic [2:0] ST_SEND = 3'd4;
    localparam logic [2:0] ST_CR   = 3'd5;
    localparam logic [2:0] ST_LF   = 3'd6;
    localparam logic [2:0] ST_FIN  = 3'd7;

    // Control codes, DEL and anything with bit 7 set would upset a host terminal.
    function automatic logic [7:0] printable(input logic [7:0] c);
        if (c < ASCII_SPACE || c == ASCII_DEL || c[7]) begin
            return ASCII_SPACE;
        end
        return c;
    endfunction

endpackage

// File: rtl/uart_tx_core.sv
// UART 8N1 serializer: one start bit, eight data bits LSB first, one stop bit,
// each CLKS_PER_BIT cycles long.
module uart_tx_core #(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       send,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);

    localparam int             CW       = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]     BIT_STOP = 4'd9;

    logic          active_q, active_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          bit_end;
    logic          accept;

    assign bit_end = (cnt_q == CNT_LAST);
    // Ready during the final stop-bit cycle lets the next frame follow without losing a cycle;
    // the stop bit still runs its full length because the new start bit begins at the next edge.
    assign ready   = !active_q || (bit_q == BIT_STOP && bit_end);
    assign accept  = send && ready;
    assign tx      = tx_q;

    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        if (active_q) begin
            if (bit_end) begin
                cnt_d = '0;
                if (bit_q == BIT_STOP) begin
                    active_d = 1'b0;
                    tx_d     = 1'b1;
                end else begin
                    // Shifting in ones makes the bit after data bit 7 the stop bit.
                    bit_d   = bit_q + 4'd1;
                    tx_d    = shift_q[0];
                    shift_d = {1'b1, shift_q[7:1]};
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        if (accept) begin
            active_d = 1'b1;
            cnt_d    = '0;
            bit_d    = 4'd0;
            shift_d  = data;
            tx_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            bit_q    <= 4'd0;
            shift_q  <= 8'hFF;
            tx_q     <= 1'b1;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
        end
    end

endmodule

// File: rtl/text_dump_tx.sv
// Screen-dump transmitter: walks the character RAM row by row, filters each byte to
// printable ASCII and sends it over UART, with CR/LF closing every row.
module text_dump_tx
    import text_term_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 9600,
    parameter int COLS   = TERM_COLS,
    parameter int ROWS   = TERM_ROWS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [1:0] rd_row,
    output logic [4:0] rd_col,
    input  logic [7:0] rd_data,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int         CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam logic [4:0] COL_LAST     = 5'(COLS - 1);
    localparam logic [1:0] ROW_LAST     = 2'(ROWS - 1);
    // CR and LF idle for as many cycles as ADDR/WAIT/LOAD so every inter-frame gap matches.
    localparam logic [1:0] PAD_LAST     = 2'd2;

    logic [2:0] state_q, state_d;
    logic [1:0] row_q, row_d;
    logic [4:0] col_q, col_d;
    logic [1:0] pad_q, pad_d;
    logic       sent_q, sent_d;
    logic       tx_send;
    logic [7:0] tx_byte;
    logic       tx_ready;

    uart_tx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx_core (
        .clk  (clk),
        .reset(reset),
        .send (tx_send),
        .data (tx_byte),
        .tx   (tx),
        .ready(tx_ready)
    );

    assign rd_row = row_q;
    assign rd_col = col_q;
    assign busy   = (state_q != ST_IDLE) && (state_q != ST_FIN);
    assign done   = (state_q == ST_FIN);

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        pad_d   = pad_q;
        sent_d  = sent_q;
        tx_send = 1'b0;
        tx_byte = printable(rd_data);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    row_d   = 2'd0;
                    col_d   = 5'd0;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: state_d = ST_WAIT;
            ST_WAIT: state_d = ST_LOAD;
            ST_LOAD: begin
                tx_send = 1'b1;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (tx_ready) begin
                    pad_d  = 2'd0;
                    sent_d = 1'b0;
                    if (col_q != COL_LAST) begin
                        col_d   = col_q + 5'd1;
                        state_d = ST_ADDR;
                    end else begin
                        state_d = ST_CR;
                    end
                end
            end
            ST_CR, ST_LF: begin
                tx_byte = (state_q == ST_CR) ? ASCII_CR : ASCII_LF;
                if (!sent_q) begin
                    if (pad_q == PAD_LAST) begin
                        tx_send = 1'b1;
                        sent_d  = 1'b1;
                    end else begin
                        pad_d = pad_q + 2'd1;
                    end
                end else if (tx_ready) begin
                    pad_d  = 2'd0;
                    sent_d = 1'b0;
                    if (state_q == ST_CR) begin
                        state_d = ST_LF;
                    end else if (row_q != ROW_LAST) begin
                        row_d   = row_q + 2'd1;
                        col_d   = 5'd0;
                        state_d = ST_ADDR;
                    end else begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            row_q   <= 2'd0;
            col_q   <= 5'd0;
            pad_q   <= 2'd0;
            sent_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            pad_q   <= pad_d;
            sent_q  <= sent_d;
        end
    end

endmodule

// File: tb/tb_text_dump_tx.sv
// Bench for text_dump_tx: a character RAM model, a cycle-exact UART frame monitor and a
// scoreboard of expected bytes, plus reset, ignored-start and gap/address sequencing scenarios.
module tb_text_dump_tx;

    localparam int BIT_CYC   = 16;
    localparam int FRAME_CYC = 10 * BIT_CYC;
    localparam int DUMP_LEN  = 136;

    logic       clk;
    logic       reset;
    logic       start;
    logic [1:0] rd_row;
    logic [4:0] rd_col;
    logic [7:0] rd_data;
    logic       tx;
    logic       busy;
    logic       done;

    text_dump_tx #(
        .CLK_HZ(16),
        .BAUD  (1)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .rd_row (rd_row),
        .rd_col (rd_col),
        .rd_data(rd_data),
        .tx     (tx),
        .busy   (busy),
        .done   (done)
    );

    // ---------------- clock / RAM model ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [0:3][0:31];
    always @(posedge clk) rd_data <= mem[rd_row][rd_col];

    // ---------------- scoreboard state ----------------
    logic [7:0] exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         done_cnt = 0;
    int         frames_in_dump = 0;
    int         first_gap = -1;
    int         mon_pos = 0;
    logic       frame_bits [0:FRAME_CYC-1];
    logic       addr_first = 1'b0;
    logic [6:0] last_addr = 7'd0;
    logic       have_last_stop = 1'b0;
    time        t_start = 0;
    time        frame_t = 0;
    time        prev_end_t = 0;
    time        last_stop_t = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_char(input logic [7:0] c);
        if (c < 8'h20 || c == 8'h7F || c >= 8'h80) return 8'h20;
        return c;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic push_dump();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 32; c++) exp_q.push_back(model_char(mem[r][c]));
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endtask

    task automatic pulse_start(input bit fresh);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        if (fresh) begin
            t_start        = $time;
            frames_in_dump = 0;
            first_gap      = -1;
            addr_first     = 1'b1;
            have_last_stop = 1'b0;
        end
        @(negedge clk);
        start = 1'b0;
        check(fresh ? "busy_rise" : "busy_held", 32'(busy), 32'd1);
        if (fresh) check("addr_at_n1", 32'({rd_row, rd_col}), 32'd0);
    endtask

    task automatic wait_done(input int d0);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 25000) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 32'(done_cnt != d0), 32'd1);
        repeat (5) @(negedge clk);
    endtask

    task automatic end_of_dump(input int d0);
        check("done_pulses", 32'(done_cnt - d0), 32'd1);
        check("dump_bytes", 32'(frames_in_dump), 32'(DUMP_LEN));
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("addr_last", 32'(last_addr), 32'd127);
        check("row_hold", 32'(rd_row), 32'd3);
        check("col_hold", 32'(rd_col), 32'd31);
        check("busy_idle", 32'(busy), 32'd0);
        check("tx_idle", 32'(tx), 32'd1);
    endtask

    // ---------------- frame monitor ----------------
    task automatic finish_frame();
        logic [7:0] byte_v;
        logic       expb;
        int         errs;
        int         j;
        for (int k = 0; k < 8; k++) byte_v[k] = frame_bits[BIT_CYC * (k + 1) + BIT_CYC / 2];
        errs = 0;
        for (int t = 0; t < FRAME_CYC; t++) begin
            j = t / BIT_CYC;
            expb = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : byte_v[j - 1];
            if (frame_bits[t] !== expb) errs++;
        end
        check("frame_shape", 32'(errs), 32'd0);
        if (exp_q.size() == 0) begin
            check("extra_byte", 32'(exp_q.size()), 32'd1);
        end else begin
            check("byte", 32'(byte_v), 32'(exp_q.pop_front()));
        end
        prev_end_t     = frame_t + FRAME_CYC * 10;
        last_stop_t    = $time;
        have_last_stop = 1'b1;
        frames_in_dump++;
    endtask

    initial begin
        int gap;
        logic [6:0] addr;
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_pos = 0;
            end else begin
                if (done) begin
                    done_cnt++;
                    check("busy_low_at_done", 32'(busy), 32'd0);
                    if (have_last_stop)
                        check("done_lat_le2", 32'((($time - last_stop_t) / 10) <= 2), 32'd1);
                end
                if (busy) begin
                    addr = {rd_row, rd_col};
                    if (addr_first) begin
                        check("addr_first", 32'(addr), 32'd0);
                        addr_first = 1'b0;
                    end else if (addr != last_addr) begin
                        check("addr_seq", 32'(addr), 32'(last_addr + 7'd1));
                    end
                    last_addr = addr;
                end
                if (mon_pos == 0) begin
                    if (tx == 1'b0) begin
                        frame_t      = $time;
                        frame_bits[0] = tx;
                        mon_pos      = 1;
                        if (frames_in_dump == 0) begin
                            check("first_start_le3", 32'(((frame_t - t_start - 5) / 10) <= 3), 32'd1);
                        end else begin
                            gap = int'((frame_t - prev_end_t) / 10);
                            check("gap_le3", 32'(gap <= 3), 32'd1);
                            if (first_gap < 0) first_gap = gap;
                            else check("gap_same", 32'(gap), 32'(first_gap));
                        end
                    end
                end else begin
                    frame_bits[mon_pos] = tx;
                    mon_pos++;
                    if (mon_pos == FRAME_CYC) begin
                        finish_frame();
                        mon_pos = 0;
                    end
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int bad;
        int d0;
        int n;
        reset = 1'b1;
        start = 1'b0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 32; c++) mem[r][c] = 8'h41 + 8'(c);
        repeat (3) @(negedge clk);
        #1;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_row", 32'(rd_row), 32'd0);
        check("rst_col", 32'(rd_col), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        check("idle_200", 32'(bad), 32'd0);

        // Alphabet pattern in every row.
        push_dump();
        d0 = done_cnt;
        pulse_start(1'b1);
        wait_done(d0);
        end_of_dump(d0);

        // Substitution boundaries plus a start request ignored mid-dump.
        mem[0][0] = 8'h07;
        mem[0][1] = 8'h7F;
        mem[0][2] = 8'hC1;
        mem[1][3] = 8'h1F;
        mem[1][4] = 8'h20;
        mem[2][5] = 8'h7E;
        mem[2][6] = 8'h80;
        mem[3][31] = 8'hFF;
        for (int c = 8; c < 16; c++) mem[3][c] = 8'($urandom_range(0, 255));
        push_dump();
        d0 = done_cnt;
        pulse_start(1'b1);
        repeat (500) @(negedge clk);
        pulse_start(1'b0);
        wait_done(d0);
        end_of_dump(d0);

        // Reset in the middle of byte 10.
        push_dump();
        pulse_start(1'b1);
        n = 0;
        while (frames_in_dump < 10 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("reach_byte10", 32'(frames_in_dump >= 10), 32'd1);
        n = 0;
        while (tx !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("byte10_start", 32'(tx), 32'd0);
        repeat (2 * BIT_CYC + BIT_CYC / 2) @(negedge clk);
        d0 = done_cnt;
        reset = 1'b1;
        #1;
        check("midrst_tx", 32'(tx), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        repeat (40) @(negedge clk);
        check("no_done_after_rst", 32'(done_cnt - d0), 32'd0);
        check("tx_after_rst", 32'(tx), 32'd1);

        push_dump();
        d0 = done_cnt;
        pulse_start(1'b1);
        wait_done(d0);
        end_of_dump(d0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
